// File: rtl/decrement_repeat_pkg.sv
// Shared types and default sizes for the held-button up/down counters.
package decrement_repeat_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DLY_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } state_e;

endpackage

// File: rtl/decrement_repeat_timer.sv
// Hold-delay counter: counts while run is high and flags when the selected limit is reached.
module repeat_timer
    import decrement_repeat_pkg::*;
#(
    parameter int unsigned DLY_W = DEFAULT_DLY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DLY_W-1:0] limit,
    output logic             terminal
);

    logic [DLY_W-1:0] delay_q, delay_d;

    // >= so a limit lowered mid-hold fires next cycle instead of waiting for a wrap
    assign terminal = (delay_q >= limit);

    always_comb begin
        delay_d = delay_q;
        if (clr) begin
            delay_d = '0;
        end else if (run) begin
            delay_d = delay_q + DLY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay_q <= '0;
        end else begin
            delay_q <= delay_d;
        end
    end

endmodule

// File: rtl/decrement_repeat.sv
// Held-button down-counter with first-step, long-hold delay and faster auto-repeat; wraps 0 -> maxCount.
module decrement_repeat
    import decrement_repeat_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DLY_W = DEFAULT_DLY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal,
    input  logic [DLY_W-1:0] delaySet,
    input  logic [DLY_W-1:0] repeatSet,
    input  logic [WIDTH-1:0] maxCount,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             decremented,
    output logic             wrapped,
    output logic [WIDTH-1:0] count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dec_q, dec_d;
    logic             wrap_q, wrap_d;
    logic             timer_clr, timer_run, timer_terminal;
    logic [DLY_W-1:0] timer_limit;
    logic [WIDTH-1:0] step_value;
    logic             step_wraps;

    assign timer_limit = (state_q == REPEAT) ? repeatSet : delaySet;

    repeat_timer #(
        .DLY_W (DLY_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .run      (timer_run),
        .limit    (timer_limit),
        .terminal (timer_terminal)
    );

    // Out-of-range values clamp to maxCount without flagging a wrap
    always_comb begin
        step_wraps = 1'b0;
        if (count_q == '0) begin
            step_value = maxCount;
            step_wraps = 1'b1;
        end else if (count_q > maxCount) begin
            step_value = maxCount;
        end else begin
            step_value = count_q - WIDTH'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dec_d     = 1'b0;
        wrap_d    = 1'b0;
        timer_clr = 1'b0;
        timer_run = 1'b0;
        if (load) begin
            count_d   = (loadValue > maxCount) ? maxCount : loadValue;
            timer_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (signal) begin
                        count_d   = step_value;
                        dec_d     = 1'b1;
                        wrap_d    = step_wraps;
                        timer_clr = 1'b1;
                        state_d   = FIRST;
                    end
                end
                FIRST, REPEAT: begin
                    if (!signal) begin
                        timer_clr = 1'b1;
                        state_d   = IDLE;
                    end else if (timer_terminal) begin
                        count_d   = step_value;
                        dec_d     = 1'b1;
                        wrap_d    = step_wraps;
                        timer_clr = 1'b1;
                        state_d   = REPEAT;
                    end else begin
                        timer_run = 1'b1;
                    end
                end
                default: begin
                    timer_clr = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            dec_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dec_q   <= dec_d;
            wrap_q  <= wrap_d;
        end
    end

    assign decremented = dec_q;
    assign wrapped     = wrap_q;
    assign count       = count_q;

endmodule
